// File: rtl/fft_frame_peak_finder.sv
// fft_frame_peak_finder
// Finds the largest L1-magnitude (|I|+|Q|) bin in each FFT frame and emits
// one registered peak report per frame. Three-stage in-order pipeline:
//   S1 |I|,|Q|   S2 mag = |I|+|Q|   S3 compare/update + report
// A sample presented with tlast in cycle N produces peak_tvalid in cycle N+3.
//
// Ports:
//   clk, aresetn      clock, asynchronous active-low reset
//   tdata             {Q, I}, each DATA_LEN/2 bits signed
//   tvalid/tlast      sample valid (no backpressure) / last bin of frame
//   tuser             frame sideband, captured on the first valid sample
//   index             bin index of the current sample
//   mag_threshold     (PEAK_THRESHOLD_EN only) minimum eligible magnitude
//   peak_tvalid       one-cycle report strobe
//   peak_index/mag    location and magnitude of the frame maximum
//   peak_tuser        frame sideband
//   peak_count        valid samples in the frame (saturating)
//   peak_found        at least one bin was eligible
//
// Optional feature macro: PEAK_THRESHOLD_EN (adds mag_threshold).
module fft_frame_peak_finder #(
    parameter int unsigned DATA_LEN  = 64,
    parameter int unsigned TUSER_LEN = 32,
    parameter int unsigned INDEX_LEN = 32,
    parameter int unsigned SKIP_BINS = 1
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic [DATA_LEN-1:0]    tdata,
    input  logic                   tvalid,
    input  logic                   tlast,
    input  logic [TUSER_LEN-1:0]   tuser,
    input  logic [INDEX_LEN-1:0]   index,
`ifdef PEAK_THRESHOLD_EN
    input  logic [DATA_LEN/2:0]    mag_threshold,
`endif
    output logic                   peak_tvalid,
    output logic [INDEX_LEN-1:0]   peak_index,
    output logic [DATA_LEN/2:0]    peak_mag,
    output logic [TUSER_LEN-1:0]   peak_tuser,
    output logic [INDEX_LEN-1:0]   peak_count,
    output logic                   peak_found
);

    localparam int unsigned HALF_W = DATA_LEN / 2;
    localparam int unsigned MAG_W  = HALF_W + 1;

    typedef enum logic {IDLE, ACCUM} state_e;

    // Unsigned magnitude; the most negative input maps to 2^(HALF_W-1).
    function automatic logic [HALF_W-1:0] abs_val(input logic [HALF_W-1:0] x);
        abs_val = x[HALF_W-1] ? HALF_W'(~x + HALF_W'(1)) : x;
    endfunction

    // S1 registers
    logic [HALF_W-1:0]    abs_i_q, abs_q_q;
    logic [INDEX_LEN-1:0] idx1_q;
    logic [TUSER_LEN-1:0] user1_q;
    logic                 vld1_q, last1_q;

    // S2 registers
    logic [MAG_W-1:0]     mag2_q;
    logic [INDEX_LEN-1:0] idx2_q;
    logic [TUSER_LEN-1:0] user2_q;
    logic                 vld2_q, last2_q;

    // S3 frame state and report registers
    state_e               state_q, state_d;
    logic [MAG_W-1:0]     best_mag_q, best_mag_d;
    logic [INDEX_LEN-1:0] best_idx_q, best_idx_d;
    logic                 found_q, found_d;
    logic [INDEX_LEN-1:0] count_q, count_d;
    logic [TUSER_LEN-1:0] tuser_q, tuser_d;

    logic                 pk_vld_q, pk_vld_d;
    logic [INDEX_LEN-1:0] pk_idx_q, pk_idx_d;
    logic [MAG_W-1:0]     pk_mag_q, pk_mag_d;
    logic [TUSER_LEN-1:0] pk_user_q, pk_user_d;
    logic [INDEX_LEN-1:0] pk_cnt_q, pk_cnt_d;
    logic                 pk_found_q, pk_found_d;

    logic                 eligible_c;

    // S1/S2 datapath
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            abs_i_q <= '0;
            abs_q_q <= '0;
            idx1_q  <= '0;
            user1_q <= '0;
            vld1_q  <= 1'b0;
            last1_q <= 1'b0;
            mag2_q  <= '0;
            idx2_q  <= '0;
            user2_q <= '0;
            vld2_q  <= 1'b0;
            last2_q <= 1'b0;
        end else begin
            abs_i_q <= abs_val(tdata[HALF_W-1:0]);
            abs_q_q <= abs_val(tdata[DATA_LEN-1:HALF_W]);
            idx1_q  <= index;
            user1_q <= tuser;
            vld1_q  <= tvalid;
            last1_q <= tlast;
            mag2_q  <= MAG_W'(abs_i_q) + MAG_W'(abs_q_q);
            idx2_q  <= idx1_q;
            user2_q <= user1_q;
            vld2_q  <= vld1_q;
            last2_q <= last1_q;
        end
    end

    // Eligibility: DC rejection, optionally gated by magnitude threshold
`ifdef PEAK_THRESHOLD_EN
    assign eligible_c = (idx2_q >= INDEX_LEN'(SKIP_BINS)) && (mag2_q >= mag_threshold);
`else
    assign eligible_c = (idx2_q >= INDEX_LEN'(SKIP_BINS));
`endif

    // S3 state register
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            best_mag_q <= '0;
            best_idx_q <= '0;
            found_q    <= 1'b0;
            count_q    <= '0;
            tuser_q    <= '0;
            pk_vld_q   <= 1'b0;
            pk_idx_q   <= '0;
            pk_mag_q   <= '0;
            pk_user_q  <= '0;
            pk_cnt_q   <= '0;
            pk_found_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            best_mag_q <= best_mag_d;
            best_idx_q <= best_idx_d;
            found_q    <= found_d;
            count_q    <= count_d;
            tuser_q    <= tuser_d;
            pk_vld_q   <= pk_vld_d;
            pk_idx_q   <= pk_idx_d;
            pk_mag_q   <= pk_mag_d;
            pk_user_q  <= pk_user_d;
            pk_cnt_q   <= pk_cnt_d;
            pk_found_q <= pk_found_d;
        end
    end

    // S3 next-state: frame accumulation and report publication
    always_comb begin
        state_d    = state_q;
        best_mag_d = best_mag_q;
        best_idx_d = best_idx_q;
        found_d    = found_q;
        count_d    = count_q;
        tuser_d    = tuser_q;
        pk_vld_d   = 1'b0;
        pk_idx_d   = pk_idx_q;
        pk_mag_d   = pk_mag_q;
        pk_user_d  = pk_user_q;
        pk_cnt_d   = pk_cnt_q;
        pk_found_d = pk_found_q;

        if (vld2_q) begin
            if (state_q == IDLE) begin
                // First sample of a frame starts a fresh search
                count_d    = INDEX_LEN'(1);
                tuser_d    = user2_q;
                best_mag_d = eligible_c ? mag2_q : '0;
                best_idx_d = eligible_c ? idx2_q : '0;
                found_d    = eligible_c;
            end else begin
                count_d = (count_q == '1) ? count_q : count_q + INDEX_LEN'(1);
                // Strict compare keeps the earliest bin on ties
                if (eligible_c && (!found_q || (mag2_q > best_mag_q))) begin
                    best_mag_d = mag2_q;
                    best_idx_d = idx2_q;
                    found_d    = 1'b1;
                end
            end

            if (last2_q) begin
                pk_vld_d   = 1'b1;
                pk_idx_d   = best_idx_d;
                pk_mag_d   = best_mag_d;
                pk_user_d  = tuser_d;
                pk_cnt_d   = count_d;
                pk_found_d = found_d;
                state_d    = IDLE;
            end else begin
                state_d = ACCUM;
            end
        end
    end

    assign peak_tvalid = pk_vld_q;
    assign peak_index  = pk_idx_q;
    assign peak_mag    = pk_mag_q;
    assign peak_tuser  = pk_user_q;
    assign peak_count  = pk_cnt_q;
    assign peak_found  = pk_found_q;

endmodule
